// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: checks head drive lines for encoding/conflict/sequence faults, plus phase-duration faults when TC_MON_DURATION_CHECK_EN is defined.
module traffic_conflict_monitor #(
  parameter int MIN_GREEN_CYC  = 8,
  parameter int MIN_YELLOW_CYC = 3,
  parameter int FLASH_HALF     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_NS_red,
  input  logic       i_NS_yellow,
  input  logic       i_NS_green,
  input  logic       i_EW_red,
  input  logic       i_EW_yellow,
  input  logic       i_EW_green,
  input  logic       i_fault_clr,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic       o_flash_red
);
  typedef enum logic [1:0] {PH_NONE, PH_RED, PH_YEL, PH_GRN} phase_e;
  localparam int FW = FLASH_HALF > 1 ? $clog2(FLASH_HALF) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  if (FLASH_HALF < 1 || MIN_GREEN_CYC < 1 || MIN_YELLOW_CYC < 1) begin : g_param_chk
    $error("traffic_conflict_monitor: parameters must be >= 1");
  end
  logic [2:0] s_q [2];
  logic [2:0] s_d [2];
  logic s_vld_q;
  phase_e p_q [2];
  phase_e p_d [2];
  phase_e cur [2];
  logic fault_q, fault_d, flash_q, flash_d;
  logic [2:0] code_q, code_d, hit_code;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic enc_err, conf_err, seq_err, short_y, short_g, clr_ok, latch;
`ifdef TC_MON_DURATION_CHECK_EN
  localparam int MAXC = MIN_GREEN_CYC > MIN_YELLOW_CYC ? MIN_GREEN_CYC : MIN_YELLOW_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MIN_G = CW'(MIN_GREEN_CYC);
  localparam logic [CW-1:0] MIN_Y = CW'(MIN_YELLOW_CYC);
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic known_q [2];
  logic known_d [2];
`endif
  always_comb begin
    s_d[0] = {i_NS_red, i_NS_yellow, i_NS_green};
    s_d[1] = {i_EW_red, i_EW_yellow, i_EW_green};
    enc_err = 1'b0;
    seq_err = 1'b0;
    short_y = 1'b0;
    short_g = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cur[d] = s_q[d] == 3'b100 ? PH_RED : s_q[d] == 3'b010 ? PH_YEL : s_q[d] == 3'b001 ? PH_GRN : PH_NONE;
      enc_err |= s_vld_q & (cur[d] == PH_NONE);
      seq_err |= (p_q[d] == PH_GRN && cur[d] == PH_RED) || (p_q[d] == PH_RED && cur[d] == PH_YEL) ||
                 (p_q[d] == PH_YEL && cur[d] == PH_GRN);
`ifdef TC_MON_DURATION_CHECK_EN
      short_y |= known_q[d] && p_q[d] == PH_YEL && cur[d] == PH_RED && cnt_q[d] < MIN_Y;
      short_g |= known_q[d] && p_q[d] == PH_GRN && cur[d] == PH_YEL && cnt_q[d] < MIN_G;
`endif
    end
    conf_err = (|s_q[0][1:0]) & (|s_q[1][1:0]);
    hit_code = enc_err ? 3'd1 : conf_err ? 3'd2 : seq_err ? 3'd3 : short_y ? 3'd4 : short_g ? 3'd5 : 3'd0;
    clr_ok = i_fault_clr & fault_q & ~enc_err & ~conf_err;
    latch = (hit_code != 3'd0) & (~fault_q | clr_ok);
    fault_d = latch | (fault_q & ~clr_ok);
    code_d = latch ? hit_code : clr_ok ? 3'd0 : code_q;
    flash_d = latch ? 1'b1 : !fault_d ? 1'b0 : fcnt_q == FLASH_LAST ? ~flash_q : flash_q;
    fcnt_d = (latch || !fault_d || fcnt_q == FLASH_LAST) ? '0 : fcnt_q + 1'b1;
    for (int d = 0; d < 2; d++) begin
      p_d[d] = clr_ok ? PH_NONE : cur[d];
`ifdef TC_MON_DURATION_CHECK_EN
      cnt_d[d] = clr_ok ? '0 : cur[d] != p_q[d] ? CW'(1) : &cnt_q[d] ? cnt_q[d] : cnt_q[d] + 1'b1;
      // entry time is only known when the phase was entered from an observed phase
      known_d[d] = !clr_ok && cur[d] != PH_NONE && (cur[d] != p_q[d] ? p_q[d] != PH_NONE : known_q[d]);
`endif
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_q <= '{default: '0};
      s_vld_q <= 1'b0;
      p_q <= '{default: PH_NONE};
      fault_q <= 1'b0;
      code_q <= '0;
      flash_q <= 1'b0;
      fcnt_q <= '0;
`ifdef TC_MON_DURATION_CHECK_EN
      cnt_q <= '{default: '0};
      known_q <= '{default: 1'b0};
`endif
    end else begin
      s_q <= s_d;
      s_vld_q <= 1'b1;
      p_q <= p_d;
      fault_q <= fault_d;
      code_q <= code_d;
      flash_q <= flash_d;
      fcnt_q <= fcnt_d;
`ifdef TC_MON_DURATION_CHECK_EN
      cnt_q <= cnt_d;
      known_q <= known_d;
`endif
    end
  end
  assign o_fault = fault_q;
  assign o_fault_code = code_q;
  assign o_flash_red = flash_q;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: directed and randomized checks against a sample-history reference model.
module tb_traffic_conflict_monitor;
  localparam int MG = 8, MY = 3, FH = 4;
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic ns_r = 0, ns_y = 0, ns_g = 0, ew_r = 0, ew_y = 0, ew_g = 0, clr = 0;
  logic o_fault, o_flash_red;
  logic [2:0] o_fault_code;
  int checks = 0, errors = 0;
  int hist_ns[$], hist_ew[$];
  logic [2:0] pv_ns, pv_ew;
  bit pv_ok = 0, m_fault = 0;
  int m_code = 0, rise_t = 0, t = 0;
  traffic_conflict_monitor #(.MIN_GREEN_CYC(MG), .MIN_YELLOW_CYC(MY), .FLASH_HALF(FH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_NS_red(ns_r), .i_NS_yellow(ns_y), .i_NS_green(ns_g),
    .i_EW_red(ew_r), .i_EW_yellow(ew_y), .i_EW_green(ew_g),
    .i_fault_clr(clr), .o_fault(o_fault), .o_fault_code(o_fault_code), .o_flash_red(o_flash_red)
  );
  always #5 i_clk = ~i_clk;
  function automatic int phase(logic [2:0] v);
    return v == RED ? 1 : v == YEL ? 2 : v == GRN ? 3 : 0;
  endfunction
  function automatic int get(int d, int i);
    return d == 0 ? hist_ns[i] : hist_ew[i];
  endfunction
  function automatic int hsize(int d);
    return d == 0 ? hist_ns.size() : hist_ew.size();
  endfunction
  function automatic int dir_code(int d, int c);
    int n = hsize(d);
    int p, j, len;
    if (n == 0 || c == 0) return 0;
    p = get(d, n - 1);
    if (p == 0) return 0;
    if ((p == 3 && c == 1) || (p == 1 && c == 2) || (p == 2 && c == 3)) return 3;
`ifdef TC_MON_DURATION_CHECK_EN
    if ((p == 2 && c == 1) || (p == 3 && c == 2)) begin
      j = n - 1;
      len = 0;
      while (j >= 0 && get(d, j) == p) begin
        j--;
        len++;
      end
      if (j >= 0 && get(d, j) != 0 && len < (p == 2 ? MY : MG)) return p == 2 ? 4 : 5;
    end
`endif
    return 0;
  endfunction
  function automatic void model_step(logic [2:0] ns, logic [2:0] ew, bit c);
    int cn = phase(ns);
    int ce = phase(ew);
    int a, b, code;
    bit ok;
    a = dir_code(0, cn);
    b = dir_code(1, ce);
    code = (cn == 0 || ce == 0) ? 1 : (ns[1:0] != 0 && ew[1:0] != 0) ? 2 :
           (a == 0) ? b : (b == 0 || a < b) ? a : b;
    ok = c && m_fault && code != 1 && code != 2;
    if (code != 0 && (!m_fault || ok)) begin
      m_fault = 1;
      m_code = code;
      rise_t = t;
    end else if (ok) begin
      m_fault = 0;
      m_code = 0;
    end
    if (ok) begin
      hist_ns.delete();
      hist_ew.delete();
    end else begin
      hist_ns.push_back(cn);
      hist_ew.push_back(ce);
      if (hist_ns.size() > 64) begin
        void'(hist_ns.pop_front());
        void'(hist_ew.pop_front());
      end
    end
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input bit c);
    {ns_r, ns_y, ns_g} = ns;
    {ew_r, ew_y, ew_g} = ew;
    clr = c;
    @(posedge i_clk);
    t++;
    if (pv_ok) model_step(pv_ns, pv_ew, c);
    pv_ns = ns;
    pv_ew = ew;
    pv_ok = 1;
    #1;
    chk("fault", o_fault, m_fault);
    chk("code", o_fault_code, m_code);
    chk("flash", o_flash_red, m_fault ? (((t - rise_t) / FH) % 2 == 0) : 0);
  endtask
  task automatic do_reset();
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_fault", o_fault, 0);
    chk("async_rst_code", o_fault_code, 0);
    chk("async_rst_flash", o_flash_red, 0);
    m_fault = 0;
    m_code = 0;
    pv_ok = 0;
    hist_ns.delete();
    hist_ew.delete();
    #1 i_rst_n = 1'b1;
  endtask
  initial begin
    int act, ph, rem;
    logic [2:0] a, ns, ew;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_fault", o_fault, 0);
    chk("reset_code", o_fault_code, 0);
    chk("reset_flash", o_flash_red, 0);
    i_rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      repeat (10) step(GRN, RED, 0);
      repeat (3) step(YEL, RED, 0);
      repeat (10) step(RED, GRN, 0);
      repeat (3) step(RED, YEL, 0);
    end
    chk("legal_fault", o_fault, 0);
    chk("legal_code", o_fault_code, 0);
    step(GRN, YEL, 0);
    chk("conflict_lat1", o_fault, 0);
    step(GRN, RED, 0);
    chk("conflict_fault", o_fault, 1);
    chk("conflict_code", o_fault_code, 2);
    chk("flash_0", o_flash_red, 1);
    for (int i = 1; i < 8; i++) begin
      step(GRN, RED, 0);
      chk("flash_seq", o_flash_red, i < 4);
    end
    step(GRN, RED, 1);
    chk("clr1_fault", o_fault, 0);
    chk("clr1_flash", o_flash_red, 0);
    step(GRN, RED, 0);
    step(RED, RED, 0);
    step(RED, RED, 0);
    chk("skip_yel_code", o_fault_code, 3);
    step(RED, RED, 1);
    chk("clr2_fault", o_fault, 0);
    chk("clr2_code", o_fault_code, 0);
    repeat (2) step(RED, RED, 0);
    repeat (8) step(GRN, RED, 0);
    repeat (3) step(YEL, RED, 0);
    repeat (2) step(RED, RED, 0);
    repeat (8) step(GRN, RED, 0);
    repeat (2) step(YEL, RED, 0);
    repeat (2) step(RED, RED, 0);
`ifdef TC_MON_DURATION_CHECK_EN
    chk("short_yel_code", o_fault_code, 4);
`else
    chk("short_yel_code", o_fault_code, 0);
`endif
    step(RED, RED, 1);
    chk("clr3_fault", o_fault, 0);
    step(3'b101, GRN, 0);
    step(RED, RED, 0);
    chk("enc_fault", o_fault, 1);
    chk("enc_code", o_fault_code, 1);
    step(GRN, GRN, 0);
    step(RED, RED, 0);
    chk("enc_sticky", o_fault_code, 1);
    do_reset();
    step(YEL, RED, 0);
    step(RED, RED, 0);
    step(RED, RED, 0);
    chk("post_rst_yel", o_fault, 0);
    act = 0;
    ph = 2;
    rem = 0;
    for (int k = 0; k < 3000; k++) begin
      if (rem == 0) begin
        ph = (ph + 1) % 3;
        if (ph == 0) act ^= 1;
        if (ph == 1 && $urandom_range(0, 15) == 0) ph = 2;
        rem = ph == 0 ? $urandom_range(4, 12) : ph == 1 ? $urandom_range(1, 5) : $urandom_range(1, 2);
      end
      rem--;
      a = ph == 0 ? GRN : ph == 1 ? YEL : RED;
      ns = act == 0 ? a : RED;
      ew = act != 0 ? a : RED;
      if ($urandom_range(0, 39) == 0) ns = 3'($urandom);
      if ($urandom_range(0, 39) == 0) ew = 3'($urandom);
      step(ns, ew, m_fault && $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
